// File: rtl/spi_slave.sv
// SPI mode-0 responder (MSB first) with a 68000-style word register bus.
// Latency: MOSI captured 3 clk after a pin SCLK rise, MISO updated 3 clk after a pin SCLK fall, ack 1 clk after strobe rise.
// Backpressure: none; one-deep RX/TX holding registers, an unread RX byte is overwritten and flagged as overrun.
module spi_slave #(
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [1:0]  addr,
    input  logic        rw,
    input  logic        uds,
    input  logic        lds,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    output logic        ack,
    output logic        irq
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state;
    logic        cs_s1, cs_s2, cs_s3;
    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        mosi_s1, mosi_s2;
    logic [2:0]  bitcnt;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_data;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_hold;
    logic        tx_full;
    logic        rx_avail;
    logic        rx_overrun;
    logic        strobe_q;

    logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic        strobe, bus_go, wr_tx, rd_rx, clr_ovr;
    logic        tx_load, rx_done;
    logic [7:0]  tx_next;
    logic [7:0]  rx_byte;
    logic        cs_active;
    logic        unused_upper;

    // Upper data lane carries nothing for this peripheral.
    assign unused_upper = ^data_write[15:8];

    // Two-flop synchronizers plus a third stage on cs/sclk for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_s3   <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            sclk_s1 <= spi_clk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    assign cs_fall   =  cs_s3 & ~cs_s2;
    assign cs_rise   = ~cs_s3 &  cs_s2;
    assign sclk_rise = ~sclk_s3 &  sclk_s2;
    assign sclk_fall =  sclk_s3 & ~sclk_s2;

    assign strobe  = uds | lds;
    assign bus_go  = strobe & ~strobe_q;
    assign wr_tx   = bus_go & ~rw & (addr == 2'd0);
    assign rd_rx   = bus_go &  rw & (addr == 2'd0);
    assign clr_ovr = bus_go & ~rw & (addr == 2'd1) & data_write[2];

    assign cs_active = (state == ACTIVE);
    assign tx_next   = tx_full ? tx_hold : FILL_BYTE;
    assign rx_byte   = {rx_shift[6:0], mosi_s2};

    // A byte is fetched from holding on select and at every byte boundary (falling edge with bitcnt wrapped).
    assign tx_load = ((state == IDLE) & cs_fall) |
                     (cs_active & ~cs_rise & sclk_fall & (bitcnt == 3'd0));
    assign rx_done = cs_active & ~cs_rise & sclk_rise & (bitcnt == 3'd7);

    assign irq = rx_avail | rx_overrun;

    // Transfer FSM, shift registers and holding/flag registers; set always beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bitcnt      <= 3'd0;
            rx_shift    <= 8'd0;
            rx_data     <= 8'd0;
            tx_shift    <= 8'd0;
            tx_hold     <= 8'd0;
            tx_full     <= 1'b0;
            rx_avail    <= 1'b0;
            rx_overrun  <= 1'b0;
            spi_miso    <= 1'b1;
            spi_miso_oe <= 1'b0;
        end else begin
            // A bus write in the same cycle as a load keeps the new byte pending.
            if (wr_tx) begin
                tx_hold <= data_write[7:0];
                tx_full <= 1'b1;
            end else if (tx_load && tx_full) begin
                tx_full <= 1'b0;
            end

            if (rx_done) begin
                rx_data <= rx_byte;
            end
            if (rx_done) begin
                rx_avail <= 1'b1;
            end else if (rd_rx) begin
                rx_avail <= 1'b0;
            end
            if (rx_done && rx_avail) begin
                rx_overrun <= 1'b1;
            end else if (clr_ovr) begin
                rx_overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state       <= ACTIVE;
                        bitcnt      <= 3'd0;
                        rx_shift    <= 8'd0;
                        tx_shift    <= tx_next;
                        spi_miso    <= tx_next[7];
                        spi_miso_oe <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bitcnt      <= 3'd0;
                        rx_shift    <= 8'd0;
                        spi_miso    <= 1'b1;
                        spi_miso_oe <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_byte;
                            bitcnt   <= bitcnt + 3'd1;
                        end
                        if (sclk_fall) begin
                            if (tx_load) begin
                                tx_shift <= tx_next;
                                spi_miso <= tx_next[7];
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                spi_miso <= tx_shift[6];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus side: access on strobe rise, one-cycle ack, read data held until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q  <= 1'b0;
            ack       <= 1'b0;
            data_read <= 16'h0000;
        end else begin
            strobe_q <= strobe;
            ack      <= bus_go;
            if (bus_go && rw) begin
                case (addr)
                    2'd0:    data_read <= {8'h00, rx_data};
                    2'd1:    data_read <= {12'h000, cs_active, rx_overrun, tx_full, rx_avail};
                    default: data_read <= 16'h0000;
                endcase
            end
        end
    end

endmodule
